// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file write arbiter slice.
// Arbiter FSM states, register index, and the buffered aux write entry.
package regfile_arb_pkg;

    localparam int unsigned ARB_XLEN = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FORCE
    } arb_state_e;

    typedef struct packed {
        reg_idx_t            rd;
        logic [ARB_XLEN-1:0] data;
    } aux_wr_t;

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// aux_wr_fifo: synchronous FIFO of aux_wr_t, DEPTH entries (power of 2).
// Ports: clk, rst (async active-low), push/din, pop/dout, full, empty, count.
module aux_wr_fifo
    import regfile_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  aux_wr_t                  din,
    input  logic                     pop,
    output aux_wr_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    aux_wr_t     mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the WB stage (priority) and
// a buffered aux writer; exports pending_mask and forces a hold on starvation.
// Ports: clk, rst (async active-low), pipe_we/rd/data, aux_valid/rd/data,
// aux_ready, wr_en/addr/data, stall_req, pending_mask.
// Optional REGFILE_ARB_STATS_EN adds stat_aux_writes and stat_force_holds.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned AUX_DEPTH  = 2,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            aux_valid,
    input  logic [4:0]      aux_rd,
    input  logic [XLEN-1:0] aux_data,
    output logic            aux_ready,
    output logic            wr_en,
    output logic [4:0]      wr_addr,
    output logic [XLEN-1:0] wr_data,
    output logic            stall_req,
    output logic [31:0]     pending_mask
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [31:0]     stat_aux_writes,
    output logic [31:0]     stat_force_holds
`endif
);

    localparam int unsigned CW = $clog2(AUX_DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_e     state;
    aux_wr_t        fifo_in;
    aux_wr_t        head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_cnt;
    logic           push;
    logic           grant_pipe;
    logic           grant_fifo;
    logic           last_pop;
    logic [SW-1:0]  starve_cnt;
    logic [SW-1:0]  starve_nxt;
    logic [31:0]    mask_nxt;

    assign aux_ready  = !fifo_full && !pending_mask[aux_rd];
    // x0 handshakes complete but are dropped here
    assign push       = aux_valid && aux_ready && (aux_rd != REG_X0);
    // During FORCE the pipe write is ignored; FIFO is never empty there
    assign grant_pipe = !stall_req && pipe_we;
    assign grant_fifo = !fifo_empty && !grant_pipe;
    assign last_pop   = grant_fifo && !push && (fifo_cnt == CW'(1));

    assign fifo_in.rd   = aux_rd;
    assign fifo_in.data = ARB_XLEN'(aux_data);

    aux_wr_fifo #(
        .DEPTH (AUX_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_in),
        .pop   (grant_fifo),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        starve_nxt = starve_cnt;
        if (fifo_empty || grant_fifo)
            starve_nxt = '0;
        else if (starve_cnt != SW'(STARVE_MAX))
            starve_nxt = starve_cnt + 1'b1;
    end

    // Push and pop never target the same register: a pushed rd is not pending
    always_comb begin
        mask_nxt = pending_mask;
        if (grant_fifo) mask_nxt[head.rd] = 1'b0;
        if (push)       mask_nxt[aux_rd]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            stall_req  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            unique case (state)
                IDLE: begin
                    if (push) state <= DRAIN;
                end
                DRAIN: begin
                    if (starve_nxt == SW'(STARVE_MAX)) begin
                        state     <= FORCE;
                        stall_req <= 1'b1;
                    end else if (last_pop) begin
                        state <= IDLE;
                    end
                end
                FORCE: begin
                    stall_req <= 1'b0;
                    state     <= last_pop ? IDLE : DRAIN;
                end
                default: begin
                    state     <= IDLE;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            pending_mask <= '0;
        end else begin
            pending_mask <= mask_nxt;
            if (grant_pipe) begin
                wr_en <= (pipe_rd != REG_X0);
                if (pipe_rd != REG_X0) begin
                    wr_addr <= pipe_rd;
                    wr_data <= pipe_data;
                end
            end else if (grant_fifo) begin
                wr_en   <= 1'b1;
                wr_addr <= head.rd;
                wr_data <= XLEN'(head.data);
            end else begin
                wr_en <= 1'b0;
            end
        end
    end

`ifdef REGFILE_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_aux_writes  <= '0;
            stat_force_holds <= '0;
        end else begin
            if (grant_fifo)       stat_aux_writes  <= stat_aux_writes + 1'b1;
            if (state == FORCE)   stat_force_holds <= stat_force_holds + 1'b1;
        end
    end
`endif

    // A WB write to a register with a queued aux write is a hazard-unit bug
    always @(posedge clk) begin
        if (rst && grant_pipe && pipe_rd != REG_X0)
            assert (!pending_mask[pipe_rd]);
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;
    localparam int XL    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pipe_we = 1'b0;
    logic [4:0]    pipe_rd = '0;
    logic [XL-1:0] pipe_data = '0;
    logic          aux_valid = 1'b0;
    logic [4:0]    aux_rd = '0;
    logic [XL-1:0] aux_data = '0;
    logic          aux_ready;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [XL-1:0] wr_data;
    logic          stall_req;
    logic [31:0]   pending_mask;
`ifdef REGFILE_ARB_STATS_EN
    logic [31:0]   stat_aux_writes;
    logic [31:0]   stat_force_holds;
`endif

    regfile_write_arbiter #(
        .AUX_DEPTH  (DEPTH),
        .STARVE_MAX (SMAX),
        .XLEN       (XL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .aux_valid    (aux_valid),
        .aux_rd       (aux_rd),
        .aux_data     (aux_data),
        .aux_ready    (aux_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .stall_req    (stall_req),
        .pending_mask (pending_mask)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .stat_aux_writes  (stat_aux_writes),
        .stat_force_holds (stat_force_holds)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model: queue of buffered writes, pending set, hold flag
    ent_t        q[$];
    bit          pend[32];
    int          starve;
    bit          force_m;
    bit          e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i] = pend[i];
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        starve  = 0;
        force_m = 1'b0;
        e_en    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_wr_en"}, wr_en, e_en);
        if (e_en) begin
            chk({tag, "_wr_addr"}, wr_addr, e_addr);
            chk({tag, "_wr_data"}, wr_data, e_data);
        end
        chk({tag, "_stall"}, stall_req, force_m);
        chk({tag, "_mask"}, pending_mask, pend_vec());
    endtask

    // One clock cycle: drive, check against model, advance model, clock
    task automatic step(input logic pwe, input logic [4:0] prd,
                        input logic [31:0] pdata, input logic av,
                        input logic [4:0] ard, input logic [31:0] adata,
                        output logic rdy);
        bit   exp_ready;
        bit   gp;
        bit   gf;
        bit   nonempty;
        ent_t e;
        pipe_we   = pwe;
        pipe_rd   = prd;
        pipe_data = pdata;
        aux_valid = av;
        aux_rd    = ard;
        aux_data  = adata;
        #1;
        exp_ready = (q.size() < DEPTH) && !pend[ard];
        rdy = aux_ready;
        chk("aux_ready", aux_ready, exp_ready);
        check_outs("cyc");
        nonempty = q.size() > 0;
        gp = !force_m && pwe;
        gf = !gp && nonempty;
        if (gp) begin
            e_en = (prd != 5'd0);
            if (e_en) begin
                e_addr = prd;
                e_data = pdata;
            end
        end else if (gf) begin
            e = q.pop_front();
            pend[e.rd] = 1'b0;
            e_en   = 1'b1;
            e_addr = e.rd;
            e_data = e.data;
        end else begin
            e_en = 1'b0;
        end
        if (!nonempty || gf) starve = 0;
        else if (starve < SMAX) starve++;
        if (av && exp_ready && ard != 5'd0) begin
            e.rd   = ard;
            e.data = adata;
            q.push_back(e);
            pend[ard] = 1'b1;
        end
        force_m = (starve == SMAX);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] free_rd();
        logic [4:0] r;
        r = 5'($urandom_range(1, 31));
        if (pend[r]) r = 5'd0;
        return r;
    endfunction

    logic r;
    int   nstall;
    int   nwr;
    bit   saw3;
    bit   saw4;

    initial begin
        model_reset();
        #12;
        check_outs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // WB writes land one cycle after request
        step(1, 5'd5, 32'd123, 0, 0, 0, r);
        chk("pipe1_en", wr_en, 1);
        chk("pipe1_addr", wr_addr, 5);
        chk("pipe1_data", wr_data, 123);
        step(1, 5'd10, 32'd999, 0, 0, 0, r);
        chk("pipe2_addr", wr_addr, 10);
        chk("pipe2_data", wr_data, 999);
        chk("pipe2_mask", pending_mask, 0);

        // Single aux write with idle pipe
        step(0, 0, 0, 1, 5'd7, 32'hDEAD, r);
        chk("aux7_ready", r, 1);
        chk("aux7_pend", pending_mask[7], 1);
        step(0, 0, 0, 0, 0, 0, r);
        chk("aux7_en", wr_en, 1);
        chk("aux7_addr", wr_addr, 7);
        chk("aux7_data", wr_data, 32'hDEAD);
        chk("aux7_clr", pending_mask[7], 0);

        // Starvation under continuous WB traffic
        nstall = 0;
        saw3 = 0;
        saw4 = 0;
        step(1, 5'd1, $urandom, 1, 5'd3, 32'hA3, r);
        step(1, 5'd2, $urandom, 1, 5'd4, 32'hA4, r);
        for (int i = 0; i < 12; i++) begin
            if (stall_req) nstall++;
            step(1, 5'd5, $urandom, 0, 0, 0, r);
            if (wr_en && wr_addr == 5'd3) saw3 = 1;
            if (wr_en && wr_addr == 5'd4) saw4 = 1;
        end
        chk("starve_holds", nstall, 2);
        chk("starve_x3", saw3, 1);
        chk("starve_x4", saw4, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, r);

        // Duplicate register and full FIFO both block aux_ready
        step(1, 5'd1, 1, 1, 5'd3, 32'h31, r);
        chk("dup_first", r, 1);
        step(1, 5'd1, 2, 1, 5'd3, 32'h32, r);
        chk("dup_second", r, 0);
        step(1, 5'd1, 3, 1, 5'd4, 32'h41, r);
        chk("fill_ready", r, 1);
        step(1, 5'd1, 4, 1, 5'd9, 32'h91, r);
        chk("full_ready", r, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, r);
        step(0, 0, 0, 1, 5'd3, 32'h33, r);
        chk("dup_retry", r, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, r);

        // x0 writes never reach the port
        nwr = 0;
        step(1, 5'd0, 32'd55, 1, 5'd0, 32'd66, r);
        chk("x0_ready", r, 1);
        for (int i = 0; i < 3; i++) begin
            if (wr_en) nwr++;
            step(0, 0, 0, 0, 0, 0, r);
        end
        chk("x0_no_write", nwr, 0);
        chk("x0_mask", pending_mask, 0);

        // Asynchronous reset with queued writes
        step(1, 5'd1, 7, 1, 5'd3, 32'hB3, r);
        step(1, 5'd2, 8, 1, 5'd4, 32'hB4, r);
        chk("prerst_mask", pending_mask, 32'h18);
        pipe_we   = 1'b1;
        pipe_rd   = 5'd6;
        aux_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_mask", pending_mask, 0);
        model_reset();
        pipe_we = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        nwr = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0, 0, r);
            if (wr_en) nwr++;
        end
        chk("postrst_no_write", nwr, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic       pwe;
            logic [4:0] prd;
            logic       av;
            logic [4:0] ard;
            pwe = ($urandom_range(0, 99) < 60);
            prd = free_rd();
            av  = ($urandom_range(0, 99) < 45);
            ard = 5'($urandom_range(0, 12));
            step(pwe, prd, $urandom, av, ard, $urandom, r);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, r);
        chk("final_empty", pending_mask, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
